// File: rtl/tb_uart_rx.sv
// rtl/tb_uart_rx.sv - harness-side UART receiver with fixed divider and byte FIFO
module tb_uart_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 rx_i,
    input  logic                 en_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 frame_err_o,
    output logic                 overflow_o,
    output logic                 busy_o
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_e;

    state_e                state_q, state_d;
    logic                  rx_meta_q, rx_s_q, rx_q;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic                  frame_err_q, frame_err_d;
    logic                  overflow_q, overflow_d;
    logic [AW:0]           wptr_q, wptr_d, rptr_q, rptr_d;
    logic [DATA_BITS-1:0]  mem_q [FIFO_DEPTH];
    logic [DATA_BITS-1:0]  mem_d [FIFO_DEPTH];
    logic                  byte_done, full, pop, push;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        byte_done   = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rx_q && !rx_s_q) begin
                    state_d = S_START;
                    cnt_d   = HALF_M1;
                end
            end
            S_START: begin
                if (cnt_q == '0) begin
                    if (!rx_s_q) begin
                        state_d = S_DATA;
                        cnt_d   = FULL_M1;
                        idx_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                    cnt_d   = FULL_M1;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_STOP: begin
                if (cnt_q == '0) begin
                    if (rx_s_q) begin
                        byte_done = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_BREAK: begin
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Disabling abandons the frame silently, including a stop bit sampled this cycle.
        if (!en_i) begin
            state_d     = S_IDLE;
            byte_done   = 1'b0;
            frame_err_d = 1'b0;
        end
    end

    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign valid_o = (wptr_q != rptr_q);
    assign pop     = valid_o && ready_i;
    assign push    = byte_done && (!full || pop);

    always_comb begin
        mem_d      = mem_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        overflow_d = byte_done && full && !pop;
        if (push) begin
            mem_d[wptr_q[AW-1:0]] = shift_q;
            wptr_d                = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_q        <= 1'b1;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            mem_q       <= '{default: '0};
        end else begin
            rx_meta_q   <= rx_i;
            rx_s_q      <= rx_meta_q;
            rx_q        <= rx_s_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            mem_q       <= mem_d;
        end
    end

    assign data_o      = mem_q[rptr_q[AW-1:0]];
    assign frame_err_o = frame_err_q;
    assign overflow_o  = overflow_q;
    assign busy_o      = (state_q != S_IDLE);

endmodule
